dram_cmd_responder: RTL and testbench

- Device-side responder for the controller FSM's 4-phase command handshake (cmd_req/cmd_ack, cmd, bank_rw, row_id, col_id).
- Captures one command per handshake and applies per-command DRAM timing with a down-counter.
- Tracks the open row of every bank and pulses read/write completion strobes.
- Sits between the controller FSM and the bank storage model/array.

---
 rtl/dram_cmd_responder_if.sv | 32 +++
 rtl/dram_cmd_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_dram_cmd_responder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/dram_cmd_responder_if.sv
// Command handshake bundle between the controller FSM (master) and the DRAM
// command responder (slave): 4-phase cmd_req/cmd_ack plus the command payload.
interface dram_cmd_responder_if #(
    parameter int BANK_W = 3,
    parameter int ROW_W  = 7,
    parameter int COL_W  = 3
) ();
    logic              cmd_req;
    logic [1:0]        cmd;
    logic [BANK_W-1:0] bank_rw;
    logic [ROW_W-1:0]  row_id;
    logic [COL_W-1:0]  col_id;
    logic              cmd_ack;

    modport master (
        output cmd_req,
        output cmd,
        output bank_rw,
        output row_id,
        output col_id,
        input  cmd_ack
    );

    modport slave (
        input  cmd_req,
        input  cmd,
        input  bank_rw,
        input  row_id,
        input  col_id,
        output cmd_ack
    );
endinterface

// File: rtl/dram_cmd_responder.sv
// Device-side DRAM command responder: captures one command per 4-phase handshake,
// applies per-command latency and tracks open rows. Optional DRAM_RSP_PROTOCOL_CHECK_EN
// adds proto_err and suppresses illegal commands.
module dram_cmd_responder #(
    parameter int NUMBER_OF_BANKS = 8,
    parameter int NUMBER_OF_ROWS  = 128,
    parameter int NUMBER_OF_COLS  = 8,
    parameter int T_RCD           = 3,
    parameter int T_CL            = 2,
    parameter int T_WR            = 2,
    parameter int T_RP            = 3,
    localparam int BANK_W         = $clog2(NUMBER_OF_BANKS),
    localparam int ROW_W          = $clog2(NUMBER_OF_ROWS),
    localparam int COL_W          = $clog2(NUMBER_OF_COLS)
) (
    input  logic                       clk,
    input  logic                       rst_b,
    dram_cmd_responder_if.slave        cmd_if,
    output logic                       busy,
    output logic [NUMBER_OF_BANKS-1:0] row_open,
    output logic                       rd_valid,
    output logic                       wr_valid,
    output logic [BANK_W-1:0]          acc_bank,
    output logic [ROW_W-1:0]           acc_row,
`ifdef DRAM_RSP_PROTOCOL_CHECK_EN
    output logic                       proto_err,
`endif
    output logic [COL_W-1:0]           acc_col
);

    localparam int T_MAX_A = (T_RCD > T_CL) ? T_RCD : T_CL;
    localparam int T_MAX_B = (T_WR > T_RP) ? T_WR : T_RP;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CNT_W   = $clog2(T_MAX) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [1:0] CMD_ACT = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    logic [1:0]                 state_r,    state_s;
    logic [CNT_W-1:0]           cnt_r,      cnt_s;
    logic [1:0]                 cap_cmd_r,  cap_cmd_s;
    logic [BANK_W-1:0]          cap_bank_r, cap_bank_s;
    logic [ROW_W-1:0]           cap_row_r,  cap_row_s;
    logic [COL_W-1:0]           cap_col_r,  cap_col_s;
    logic                       ack_r,      ack_s;
    logic                       busy_r,     busy_s;
    logic                       rd_valid_r, rd_valid_s;
    logic                       wr_valid_r, wr_valid_s;
    logic [BANK_W-1:0]          acc_bank_r, acc_bank_s;
    logic [ROW_W-1:0]           acc_row_r,  acc_row_s;
    logic [COL_W-1:0]           acc_col_r,  acc_col_s;
    logic [NUMBER_OF_BANKS-1:0] row_open_r, row_open_s;
    logic [ROW_W-1:0]           open_row_r [NUMBER_OF_BANKS];
    logic                       act_we_s;
    logic                       cmd_err_s;
    logic                       done_s;

    // Execution latency minus one, so that EXEC lasts exactly T cycles.
    function automatic logic [CNT_W-1:0] load_value(input logic [1:0] c);
        logic [CNT_W-1:0] v;
        case (c)
            CMD_ACT: v = CNT_W'(T_RCD - 1);
            CMD_RD:  v = CNT_W'(T_CL - 1);
            CMD_WR:  v = CNT_W'(T_WR - 1);
            CMD_PRE: v = CNT_W'(T_RP - 1);
            default: v = {CNT_W{1'b0}};
        endcase
        return v;
    endfunction

    // The command completes on the edge where EXEC sees an expired counter.
    always_comb begin
        if ((state_r == ST_EXEC) && (cnt_r == {CNT_W{1'b0}})) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Illegal-command detection against the current bank state.
    always_comb begin
`ifdef DRAM_RSP_PROTOCOL_CHECK_EN
        case (cap_cmd_r)
            CMD_ACT: cmd_err_s = row_open_r[cap_bank_r];
            CMD_RD:  cmd_err_s = ~row_open_r[cap_bank_r];
            CMD_WR:  cmd_err_s = ~row_open_r[cap_bank_r];
            default: cmd_err_s = 1'b0;
        endcase
`else
        cmd_err_s = 1'b0;
`endif
    end

    // Handshake FSM, capture, countdown and command effect.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        cap_cmd_s  = cap_cmd_r;
        cap_bank_s = cap_bank_r;
        cap_row_s  = cap_row_r;
        cap_col_s  = cap_col_r;
        ack_s      = ack_r;
        busy_s     = busy_r;
        rd_valid_s = 1'b0;
        wr_valid_s = 1'b0;
        acc_bank_s = acc_bank_r;
        acc_row_s  = acc_row_r;
        acc_col_s  = acc_col_r;
        row_open_s = row_open_r;
        act_we_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (cmd_if.cmd_req) begin
                    cap_cmd_s  = cmd_if.cmd;
                    cap_bank_s = cmd_if.bank_rw;
                    cap_row_s  = cmd_if.row_id;
                    cap_col_s  = cmd_if.col_id;
                    cnt_s      = load_value(cmd_if.cmd);
                    state_s    = ST_EXEC;
                    busy_s     = 1'b1;
                end else begin
                    busy_s     = 1'b0;
                end
            end
            ST_EXEC: begin
                if (done_s) begin
                    state_s = ST_ACK;
                    ack_s   = 1'b1;
                    if (!cmd_err_s) begin
                        case (cap_cmd_r)
                            CMD_ACT: begin
                                act_we_s               = 1'b1;
                                row_open_s[cap_bank_r] = 1'b1;
                            end
                            CMD_PRE: begin
                                row_open_s[cap_bank_r] = 1'b0;
                            end
                            CMD_RD: begin
                                rd_valid_s = 1'b1;
                                acc_bank_s = cap_bank_r;
                                acc_row_s  = open_row_r[cap_bank_r];
                                acc_col_s  = cap_col_r;
                            end
                            CMD_WR: begin
                                wr_valid_s = 1'b1;
                                acc_bank_s = cap_bank_r;
                                acc_row_s  = open_row_r[cap_bank_r];
                                acc_col_s  = cap_col_r;
                            end
                            default: begin
                                act_we_s = 1'b0;
                            end
                        endcase
                    end else begin
                        act_we_s = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (!cmd_if.cmd_req) begin
                    ack_s   = 1'b0;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    ack_s   = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ack_s   = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            cap_cmd_r  <= 2'b00;
            cap_bank_r <= {BANK_W{1'b0}};
            cap_row_r  <= {ROW_W{1'b0}};
            cap_col_r  <= {COL_W{1'b0}};
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            wr_valid_r <= 1'b0;
            acc_bank_r <= {BANK_W{1'b0}};
            acc_row_r  <= {ROW_W{1'b0}};
            acc_col_r  <= {COL_W{1'b0}};
            row_open_r <= {NUMBER_OF_BANKS{1'b0}};
            for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
                open_row_r[b] <= {ROW_W{1'b0}};
            end
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            cap_cmd_r  <= cap_cmd_s;
            cap_bank_r <= cap_bank_s;
            cap_row_r  <= cap_row_s;
            cap_col_r  <= cap_col_s;
            ack_r      <= ack_s;
            busy_r     <= busy_s;
            rd_valid_r <= rd_valid_s;
            wr_valid_r <= wr_valid_s;
            acc_bank_r <= acc_bank_s;
            acc_row_r  <= acc_row_s;
            acc_col_r  <= acc_col_s;
            row_open_r <= row_open_s;
            if (act_we_s) begin
                open_row_r[cap_bank_r] <= cap_row_r;
            end
        end
    end

`ifdef DRAM_RSP_PROTOCOL_CHECK_EN
    logic proto_err_r;

    // One-cycle error pulse coinciding with the ack-entry edge.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            proto_err_r <= 1'b0;
        end else begin
            proto_err_r <= done_s & cmd_err_s;
        end
    end

    assign proto_err = proto_err_r;
`endif

    assign cmd_if.cmd_ack = ack_r;
    assign busy           = busy_r;
    assign row_open       = row_open_r;
    assign rd_valid       = rd_valid_r;
    assign wr_valid       = wr_valid_r;
    assign acc_bank       = acc_bank_r;
    assign acc_row        = acc_row_r;
    assign acc_col        = acc_col_r;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Self-checking bench for dram_cmd_responder: directed handshake scenarios followed by
// random commands, all checked against a bank-state reference model.
module tb_dram_cmd_responder;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       busy;
    logic [7:0] row_open;
    logic       rd_valid;
    logic       wr_valid;
    logic [2:0] acc_bank;
    logic [6:0] acc_row;
    logic [2:0] acc_col;
`ifdef DRAM_RSP_PROTOCOL_CHECK_EN
    logic       proto_err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model of the device-visible state
    logic [7:0] ro_m;
    logic [6:0] or_m [8];
    logic [2:0] acc_b_m;
    logic [6:0] acc_r_m;
    logic [2:0] acc_c_m;

    dram_cmd_responder_if #(.BANK_W(3), .ROW_W(7), .COL_W(3)) cif ();

    dram_cmd_responder dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .cmd_if   (cif.slave),
        .busy     (busy),
        .row_open (row_open),
        .rd_valid (rd_valid),
        .wr_valid (wr_valid),
        .acc_bank (acc_bank),
        .acc_row  (acc_row),
`ifdef DRAM_RSP_PROTOCOL_CHECK_EN
        .proto_err(proto_err),
`endif
        .acc_col  (acc_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [1:0] c);
        case (c)
            2'b00:   return 3;
            2'b01:   return 2;
            2'b10:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ro_m    = 8'h00;
        acc_b_m = 3'd0;
        acc_r_m = 7'd0;
        acc_c_m = 3'd0;
        for (int i = 0; i < 8; i++) or_m[i] = 7'd0;
    endtask

    // One full handshake; hold = extra ACK cycles with req high, early = req drops during EXEC
    task automatic do_cmd(input logic [1:0] c, input int b, input int r, input int col,
                          input int hold, input bit early);
        int  t;
        bit  err;
        bit  exp_rd;
        bit  exp_wr;
        t = lat(c);
        cif.cmd_req = 1'b1;
        cif.cmd     = c;
        cif.bank_rw = 3'(b);
        cif.row_id  = 7'(r);
        cif.col_id  = 3'(col);
        tick();
        check("busy_at_capture", 32'(busy), 32'd1);
        check("ack_at_capture", 32'(cif.cmd_ack), 32'd0);
        cif.cmd     = 2'($urandom);
        cif.bank_rw = 3'($urandom);
        cif.row_id  = 7'($urandom);
        cif.col_id  = 3'($urandom);
        if (early) cif.cmd_req = 1'b0;

        err = 1'b0;
`ifdef DRAM_RSP_PROTOCOL_CHECK_EN
        err = ((c == 2'b01 || c == 2'b10) && !ro_m[b]) || (c == 2'b00 && ro_m[b]);
`endif
        exp_rd = 1'b0;
        exp_wr = 1'b0;
        if (!err) begin
            case (c)
                2'b00: begin ro_m[b] = 1'b1; or_m[b] = 7'(r); end
                2'b11: ro_m[b] = 1'b0;
                default: begin
                    exp_rd  = (c == 2'b01);
                    exp_wr  = (c == 2'b10);
                    acc_b_m = 3'(b);
                    acc_r_m = or_m[b];
                    acc_c_m = 3'(col);
                end
            endcase
        end

        for (int k = 1; k <= t; k++) begin
            tick();
            check("ack_latency", 32'(cif.cmd_ack), 32'(k == t));
            check("busy_exec", 32'(busy), 32'd1);
        end
        check("rd_valid_done", 32'(rd_valid), 32'(exp_rd));
        check("wr_valid_done", 32'(wr_valid), 32'(exp_wr));
        check("acc_bank", 32'(acc_bank), 32'(acc_b_m));
        check("acc_row", 32'(acc_row), 32'(acc_r_m));
        check("acc_col", 32'(acc_col), 32'(acc_c_m));
        check("row_open_done", 32'(row_open), 32'(ro_m));
`ifdef DRAM_RSP_PROTOCOL_CHECK_EN
        check("proto_err_done", 32'(proto_err), 32'(err));
`endif
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check("ack_hold", 32'(cif.cmd_ack), 32'd1);
                check("busy_hold", 32'(busy), 32'd1);
                check("rd_pulse_end", 32'(rd_valid | wr_valid), 32'd0);
            end
            cif.cmd_req = 1'b0;
        end
        tick();
        check("ack_fall", 32'(cif.cmd_ack), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
        check("strobe_single", 32'(rd_valid | wr_valid), 32'd0);
`ifdef DRAM_RSP_PROTOCOL_CHECK_EN
        check("proto_err_single", 32'(proto_err), 32'd0);
`endif
    endtask

    initial begin
        model_reset();
        rst_b       = 1'b0;
        cif.cmd_req = 1'b1;
        cif.cmd     = 2'b00;
        cif.bank_rw = 3'd5;
        cif.row_id  = 7'h2A;
        cif.col_id  = 3'd0;

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ack", 32'(cif.cmd_ack), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_row_open", 32'(row_open), 32'h00);
            check("rst_rd_valid", 32'(rd_valid), 32'd0);
            check("rst_acc_bank", 32'(acc_bank), 32'd0);
        end
        rst_b = 1'b1;

        do_cmd(2'b00, 5, 8'h2A, 0, 0, 1'b0);
        do_cmd(2'b01, 5, 0, 6, 0, 1'b0);
        do_cmd(2'b10, 5, 0, 3, 1, 1'b0);
        do_cmd(2'b11, 5, 0, 0, 0, 1'b0);
        check("row_open_after_pre", 32'(row_open), 32'h00);

        // Back-to-back: ack held, then immediate re-request
        do_cmd(2'b00, 1, 7'h11, 0, 3, 1'b0);
        do_cmd(2'b00, 1, 7'h22, 0, 0, 1'b0);
        do_cmd(2'b11, 6, 0, 0, 0, 1'b0);
        do_cmd(2'b01, 2, 0, 4, 0, 1'b0);
        do_cmd(2'b10, 1, 0, 7, 0, 1'b1);

        // Reset in the middle of a command
        cif.cmd_req = 1'b1;
        cif.cmd     = 2'b00;
        cif.bank_rw = 3'd3;
        cif.row_id  = 7'h55;
        tick();
        tick();
        rst_b = 1'b0;
        tick();
        model_reset();
        check("midrst_ack", 32'(cif.cmd_ack), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_row_open", 32'(row_open), 32'h00);
        check("midrst_acc_row", 32'(acc_row), 32'd0);
        cif.cmd_req = 1'b0;
        rst_b = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        do_cmd(2'b01, 1, 0, 2, 0, 1'b0);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                tick();
                check("idle_ack", 32'(cif.cmd_ack), 32'd0);
            end
            do_cmd(2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                   ($urandom_range(0, 4) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
